// File: rtl/game_pkg.sv
// Shared types and fixed geometry for the obstacle game: state encoding,
// screen/player/obstacle dimensions, obstacle lanes and start positions.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    typedef logic [9:0] coord_t;

    localparam int NUM_OBS  = 4;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int PLAYER_X = 40;
    localparam int PLAYER_W = 51;
    localparam int PLAYER_H = 50;

    localparam int OBS_W    = 150;
    localparam int OBS_H    = 30;

    localparam coord_t PLAYER_Y_INIT = 10'd200;
    localparam coord_t PLAYER_Y_MAX  = coord_t'(SCREEN_H - PLAYER_H);
    localparam coord_t OBS_X_WRAP    = coord_t'(SCREEN_W);

    localparam coord_t LANE_Y     [NUM_OBS] = '{10'd100, 10'd200, 10'd150, 10'd350};
    localparam coord_t OBS_X_INIT [NUM_OBS] = '{10'd455, 10'd400, 10'd250, 10'd285};

endpackage

// File: rtl/rect_overlap.sv
// Axis-aligned rectangle intersection test (strict, touching edges do not overlap).
// Latency: combinational.
// Backpressure: none.
module rect_overlap (
    input  logic [9:0] a_x,
    input  logic [9:0] a_y,
    input  logic [9:0] a_w,
    input  logic [9:0] a_h,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    input  logic [9:0] b_w,
    input  logic [9:0] b_h,
    output logic       overlap
);

    // One extra bit so right/bottom edges near the screen limit cannot wrap.
    logic [10:0] a_right, a_bottom, b_right, b_bottom;

    assign a_right  = {1'b0, a_x} + {1'b0, a_w};
    assign a_bottom = {1'b0, a_y} + {1'b0, a_h};
    assign b_right  = {1'b0, b_x} + {1'b0, b_w};
    assign b_bottom = {1'b0, b_y} + {1'b0, b_h};

    assign overlap = ({1'b0, a_x} < b_right)  &&
                     ({1'b0, b_x} < a_right)  &&
                     ({1'b0, a_y} < b_bottom) &&
                     ({1'b0, b_y} < a_bottom);

endmodule

// File: rtl/game_controller.sv
// Frame-rate sequencer: player/obstacle motion, collision, IDLE/PLAY/HIT/OVER flow.
// Latency: outputs registered, update 1 clock after the causing frame_tick.
// Backpressure: none; all state advances only on frame_tick, otherwise holds.
module game_controller
    import game_pkg::*;
#(
    parameter int SPEED      = 2,
    parameter int STEP       = 4,
    parameter int HIT_FRAMES = 60,
    parameter int LIVES      = 3
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_start,
    output logic [9:0]  player_y,
    output logic [39:0] obs_x,
    output logic [1:0]  state,
    output logic [1:0]  lives,
    output logic [7:0]  score,
    output logic        hit_flash
);

    // At least 4 bits so that bit 3 (the blink phase) always exists.
    localparam int CNT_W = ($clog2(HIT_FRAMES + 1) > 4) ? $clog2(HIT_FRAMES + 1) : 4;

    localparam logic [10:0]      SPEED_W    = 11'(SPEED);
    localparam logic [10:0]      STEP_W     = 11'(STEP);
    localparam logic [10:0]      PY_MAX_W   = {1'b0, PLAYER_Y_MAX};
    localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

    state_t            state_q, state_d;
    coord_t            player_y_q, player_y_d;
    coord_t            obs_q [NUM_OBS];
    coord_t            obs_d [NUM_OBS];
    logic [1:0]        lives_q, lives_d;
    logic [7:0]        score_q, score_d;
    logic              flash_q, flash_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              start_prev_q;

    logic              start_edge;
    logic [NUM_OBS-1:0] hit_vec;
    coord_t            obs_moved [NUM_OBS];
    logic [2:0]        wrap_cnt;
    logic [10:0]       py_ext, py_up, py_down;
    logic [CNT_W-1:0]  cnt_inc;

    assign start_edge = btn_start & ~start_prev_q;
    assign cnt_inc    = cnt_q + 1'b1;

    for (genvar i = 0; i < NUM_OBS; i++) begin : g_overlap
        rect_overlap u_overlap (
            .a_x     (coord_t'(PLAYER_X)),
            .a_y     (player_y_q),
            .a_w     (coord_t'(PLAYER_W)),
            .a_h     (coord_t'(PLAYER_H)),
            .b_x     (obs_q[i]),
            .b_y     (LANE_Y[i]),
            .b_w     (coord_t'(OBS_W)),
            .b_h     (coord_t'(OBS_H)),
            .overlap (hit_vec[i])
        );
    end

    // Candidate motion for a clean PLAY tick; clamp/wrap done at 11 bits.
    always_comb begin
        wrap_cnt = 3'd0;
        for (int i = 0; i < NUM_OBS; i++) begin
            obs_moved[i] = obs_q[i];
            if ({1'b0, obs_q[i]} < SPEED_W) begin
                obs_moved[i] = OBS_X_WRAP;
                wrap_cnt     = wrap_cnt + 3'd1;
            end else begin
                obs_moved[i] = coord_t'({1'b0, obs_q[i]} - SPEED_W);
            end
        end

        py_ext  = {1'b0, player_y_q};
        py_up   = (py_ext < STEP_W) ? 11'd0 : (py_ext - STEP_W);
        py_down = ((py_ext + STEP_W) > PY_MAX_W) ? PY_MAX_W : (py_ext + STEP_W);
    end

    always_comb begin
        state_d    = state_q;
        player_y_d = player_y_q;
        obs_d      = obs_q;
        lives_d    = lives_q;
        score_d    = score_q;
        flash_d    = 1'b0;
        cnt_d      = cnt_q;

        if (frame_tick) begin
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_d = PLAY;
                        lives_d = LIVES_INIT;
                        score_d = 8'd0;
                    end
                end
                PLAY: begin
                    if (|hit_vec) begin
                        state_d = HIT;
                        lives_d = lives_q - 2'd1;
                        cnt_d   = '0;
                    end else begin
                        if (btn_up && !btn_down) begin
                            player_y_d = coord_t'(py_up);
                        end else if (btn_down && !btn_up) begin
                            player_y_d = coord_t'(py_down);
                        end
                        obs_d   = obs_moved;
                        score_d = score_q + 8'(wrap_cnt);
                    end
                end
                HIT: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == HIT_LAST) begin
                        if (lives_q == 2'd0) begin
                            state_d = OVER;
                        end else begin
                            state_d    = PLAY;
                            player_y_d = PLAYER_Y_INIT;
                            obs_d      = OBS_X_INIT;
                        end
                    end else begin
                        flash_d = cnt_inc[3];
                    end
                end
                OVER: begin
                    if (start_edge) begin
                        state_d    = IDLE;
                        player_y_d = PLAYER_Y_INIT;
                        obs_d      = OBS_X_INIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            flash_d = flash_q;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q      <= IDLE;
            player_y_q   <= PLAYER_Y_INIT;
            obs_q        <= OBS_X_INIT;
            lives_q      <= 2'd0;
            score_q      <= 8'd0;
            flash_q      <= 1'b0;
            cnt_q        <= '0;
            start_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            player_y_q <= player_y_d;
            obs_q      <= obs_d;
            lives_q    <= lives_d;
            score_q    <= score_d;
            flash_q    <= flash_d;
            cnt_q      <= cnt_d;
            if (frame_tick) begin
                start_prev_q <= btn_start;
            end
        end
    end

    assign player_y  = player_y_q;
    assign obs_x     = {obs_q[3], obs_q[2], obs_q[1], obs_q[0]};
    assign state     = state_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign hit_flash = flash_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: start, movement, wrap/score, hit flow,
// game over and mid-game reset, with hand-computed expectations.
module tb_game_controller;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b0;
    logic        frame_tick = 1'b0;
    logic        btn_up     = 1'b0;
    logic        btn_down   = 1'b0;
    logic        btn_start  = 1'b0;
    logic [9:0]  player_y;
    logic [39:0] obs_x;
    logic [1:0]  state;
    logic [1:0]  lives;
    logic [7:0]  score;
    logic        hit_flash;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [39:0] OBS_INIT = {10'd285, 10'd250, 10'd400, 10'd455};
    localparam logic [39:0] OBS_OVER = {10'd616, 10'd582, 10'd90, 10'd145};

    game_controller dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_start  (btn_start),
        .player_y   (player_y),
        .obs_x      (obs_x),
        .state      (state),
        .lives      (lives),
        .score      (score),
        .hit_flash  (hit_flash)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame: tick high for exactly one posedge; outputs sampled at the following negedge.
    task automatic tick();
        @(negedge clk_100MHz);
        frame_tick = 1'b1;
        @(negedge clk_100MHz);
        frame_tick = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        @(negedge clk_100MHz);
        reset = 1'b1;
        @(negedge clk_100MHz);
        reset = 1'b0;
    endtask

    task automatic start_game();
        btn_start = 1'b0;
        tick();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"}, 64'(state), 64'd0);
        check({tag, "_lives"}, 64'(lives), 64'd0);
        check({tag, "_score"}, 64'(score), 64'd0);
        check({tag, "_flash"}, 64'(hit_flash), 64'd0);
        check({tag, "_py"},    64'(player_y), 64'd200);
        check({tag, "_obs"},   64'(obs_x), 64'(OBS_INIT));
    endtask

    initial begin
        // Start held through reset must be ignored.
        btn_start = 1'b1;
        do_reset();
        check_reset_state("rst");
        run_ticks(3);
        check("held_start_idle", 64'(state), 64'd0);

        start_game();
        check("start_state", 64'(state), 64'd1);
        check("start_lives", 64'(lives), 64'd3);
        check("start_score", 64'(score), 64'd0);

        // Player movement and clamping.
        btn_up = 1'b1;
        run_ticks(10);
        check("up10_py", 64'(player_y), 64'd160);
        run_ticks(50);
        check("up_clamp_py", 64'(player_y), 64'd0);
        btn_up   = 1'b0;
        btn_down = 1'b1;
        run_ticks(5);
        check("down5_py", 64'(player_y), 64'd20);
        btn_up = 1'b1;
        run_ticks(3);
        check("both_py", 64'(player_y), 64'd20);
        check("both_state", 64'(state), 64'd1);
        btn_up   = 1'b0;
        btn_down = 1'b0;

        // Obstacle motion, wrap and score.
        do_reset();
        start_game();
        run_ticks(10);
        check("obs0_t10", 64'(obs_x[9:0]), 64'd435);
        run_ticks(115);
        check("obs2_t125", 64'(obs_x[29:20]), 64'd0);
        check("score_t125", 64'(score), 64'd0);
        tick();
        check("obs2_wrap", 64'(obs_x[29:20]), 64'd640);
        check("score_t126", 64'(score), 64'd1);
        run_ticks(16);
        check("obs3_t142", 64'(obs_x[39:30]), 64'd1);
        tick();
        check("obs3_wrap", 64'(obs_x[39:30]), 64'd640);
        check("score_t143", 64'(score), 64'd2);
        run_ticks(12);
        check("obs1_t155", 64'(obs_x[19:10]), 64'd90);
        check("state_t155", 64'(state), 64'd1);

        // First hit and the HIT interval.
        tick();
        check("hit1_state", 64'(state), 64'd2);
        check("hit1_lives", 64'(lives), 64'd2);
        check("hit1_obs1", 64'(obs_x[19:10]), 64'd90);
        check("hit1_flash", 64'(hit_flash), 64'd0);
        run_ticks(7);
        check("flash_t7", 64'(hit_flash), 64'd0);
        tick();
        check("flash_t8", 64'(hit_flash), 64'd1);
        run_ticks(7);
        check("flash_t15", 64'(hit_flash), 64'd1);
        tick();
        check("flash_t16", 64'(hit_flash), 64'd0);
        run_ticks(43);
        check("hit_t59_state", 64'(state), 64'd2);
        tick();
        check("resume_state", 64'(state), 64'd1);
        check("resume_py", 64'(player_y), 64'd200);
        check("resume_obs", 64'(obs_x), 64'(OBS_INIT));
        check("resume_flash", 64'(hit_flash), 64'd0);
        check("resume_score", 64'(score), 64'd2);

        // Second and third hits lead to OVER.
        run_ticks(156);
        check("hit2_state", 64'(state), 64'd2);
        check("hit2_lives", 64'(lives), 64'd1);
        check("hit2_score", 64'(score), 64'd4);
        run_ticks(60);
        check("resume2_state", 64'(state), 64'd1);
        run_ticks(156);
        check("hit3_lives", 64'(lives), 64'd0);
        run_ticks(60);
        check("over_state", 64'(state), 64'd3);
        check("over_lives", 64'(lives), 64'd0);
        check("over_score", 64'(score), 64'd6);
        check("over_obs", 64'(obs_x), 64'(OBS_OVER));
        check("over_flash", 64'(hit_flash), 64'd0);
        run_ticks(5);
        check("frozen_state", 64'(state), 64'd3);
        check("frozen_obs", 64'(obs_x), 64'(OBS_OVER));
        check("frozen_py", 64'(player_y), 64'd200);
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        check("over_idle_state", 64'(state), 64'd0);
        check("over_idle_obs", 64'(obs_x), 64'(OBS_INIT));
        check("over_idle_score", 64'(score), 64'd6);
        start_game();
        check("restart_score", 64'(score), 64'd0);
        check("restart_lives", 64'(lives), 64'd3);

        // Reset in the middle of HIT, coinciding with a frame tick.
        do_reset();
        start_game();
        run_ticks(156);
        check("mid_hit_state", 64'(state), 64'd2);
        run_ticks(10);
        check("mid_hit_flash", 64'(hit_flash), 64'd1);
        @(negedge clk_100MHz);
        reset      = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk_100MHz);
        reset      = 1'b0;
        frame_tick = 1'b0;
        check_reset_state("midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_controller.md
# game_controller

Frame-rate game sequencer for the VGA obstacle display. It owns the player box's vertical position and the four obstacles' horizontal positions, and advances them once per video frame from button inputs. It detects player/obstacle overlap and runs the IDLE/PLAY/HIT/OVER game flow. Its position, state, lives and score outputs feed the pixel generator, which draws each object from them.

## Interface
Parameters:
- SPEED, 2: obstacle leftward step in px per frame
- STEP, 4: player vertical step in px per frame
- HIT_FRAMES, 60: number of frames spent in HIT
- LIVES, 3: lives granted at game start (1..3)

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame, asserted during vertical blanking
- btn_up  in  1  debounced level
- btn_down  in  1  debounced level
- btn_start  in  1  debounced level
- player_y  out  10  player box top edge; reset value 200
- obs_x  out  40  packed {obs3,obs2,obs1,obs0} obstacle left edges; reset value {285,250,400,455}
- state  out  2  IDLE=0, PLAY=1, HIT=2, OVER=3; reset value IDLE
- lives  out  2  reset value 0
- score  out  8  reset value 0
- hit_flash  out  1  blink enable; reset value 0

## Operation
- Fixed geometry:
  - Player: x=40, W=51, H=50.
  - Obstacles: W=150, H=30.
  - Lane top edges for obs0..3: 100, 200, 150, 350.
  - Screen: 640x480.
- All state changes occur only on cycles where frame_tick=1. Reset takes priority over frame_tick.
- start_edge: a rising edge of btn_start sampled across consecutive frame_ticks. start_prev is updated on every tick; its reset value is 1, so a button held through reset is ignored.
- IDLE:
  - Positions are held at their initial values.
  - On start_edge: go to PLAY, lives=LIVES, score=0.
- PLAY, each tick:
  - Overlap is evaluated on the current (pre-update) registered positions.
  - Overlap with obstacle i exists when all hold: 40 < ox_i+150, ox_i < 91, py < lane_i+30, lane_i < py+50.
  - If any obstacle overlaps:
    - go to HIT and set lives = lives−1;
    - clear the frame counter;
    - leave positions unchanged this tick.
  - Otherwise:
    - Player moves up on btn_up only: py = max(py−STEP, 0).
    - Player moves down on btn_down only: py = min(py+STEP, 430).
    - Both or neither pressed: player holds.
    - Each obstacle: if ox < SPEED then ox = 640 (wrap), else ox = ox−SPEED.
    - score += number of obstacles wrapping this tick (0..4), modulo 256.
- HIT:
  - The frame counter increments per tick.
  - hit_flash = counter bit 3.
  - After HIT_FRAMES ticks in HIT:
    - if lives==0, go to OVER;
    - otherwise go to PLAY with player_y and obs_x restored to their initial values.
- OVER:
  - Positions, lives and score are frozen.
  - On start_edge: go to IDLE with positions restored. score is kept until the next game start.
- hit_flash is 0 in every state except HIT.

## Timing
- All outputs are registered. They update in the cycle after the frame_tick that causes the change, giving a latency of 1 clock.
- frame_tick held for more than one cycle is a protocol violation; behaviour is undefined.
- Reset asserted mid-game (any state) returns every output to its reset value in the next cycle. Frame counter and start_prev are reset as well.
- Width rules:
  - Positions use 11-bit intermediates; clamps and wrap are applied before truncation to 10 bits.
  - The lives decrement never underflows, because HIT is entered only with lives ≥ 1.

## Structure
- Package game_pkg holds:
  - the state enum;
  - screen, player and obstacle geometry constants;
  - the lane Y array and the initial X array.
- Sub-module rect_overlap: a combinational AABB test, instantiated four times, one per obstacle.
- The FSM, position registers, score and frame counter live in game_controller.

## Test plan
- Reset, then btn_start pulse across ticks -> state=PLAY, lives=3, score=0. A start held through reset alone does not leave IDLE.
- PLAY, btn_up held for 10 ticks -> player_y=160. Held for 60 ticks -> player_y clamps at 0. btn_up and btn_down together -> player_y unchanged.
- PLAY with no buttons:
  - obs0=435 after 10 ticks;
  - obs2 wraps to 640 on tick 126, score=1;
  - obs3 wraps on tick 143, score=2.
- PLAY with no buttons, player at 200: HIT on tick 156 (obs1=90 pre-update), lives=2, hit_flash toggles every 8 ticks. 60 ticks later -> PLAY, positions at initial values.
- Three hits -> OVER, lives=0, outputs frozen. start_edge -> IDLE.
- Reset asserted mid-HIT -> next cycle state=IDLE, lives=0, score=0, hit_flash=0, positions at initial values.
